// File: rtl/instr_mem_bridge.sv
// instr_mem_bridge
//   Connects an OpenRAM-style instruction SRAM (active-low csb/web) to two sources:
//   a host port on the req/gnt side of a tlul_sram_adapter, and a boot programming port.
//   A mode FSM (RUN / DRAIN / PROG) decides which source owns the SRAM. On the way
//   from RUN to PROG it lets in-flight host reads return first.
//   Other features: SRAM read latency set by SramRdLat, error responses for
//   out-of-range accesses, and a counter of words written per programming session.
//   Optional feature: define INSTR_MEM_WLOCK_EN to lock host writes once any
//   programming session has ended. Only rst_ni clears the lock.
module instr_mem_bridge #(
  parameter int unsigned AddrW     = 12,
  parameter int unsigned DataW     = 32,
  parameter int unsigned Depth     = 4096,
  parameter int unsigned SramRdLat = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_rst_ni,
  input  logic              host_req_i,
  output logic              host_gnt_o,
  input  logic              host_we_i,
  input  logic [AddrW-1:0]  host_addr_i,
  input  logic [DataW-1:0]  host_wdata_i,
  input  logic [DataW-1:0]  host_wmask_i,
  output logic [DataW-1:0]  host_rdata_o,
  output logic              host_rvalid_o,
  output logic [1:0]        host_rerror_o,
  output logic              host_werr_o,
  input  logic              prog_we_i,
  input  logic [AddrW-1:0]  prog_addr_i,
  input  logic [DataW-1:0]  prog_wdata_i,
  output logic              prog_ready_o,
  output logic [AddrW:0]    prog_cnt_o,
  output logic              sram_csb_o,
  output logic              sram_web_o,
  output logic [AddrW-1:0]  sram_addr_o,
  output logic [DataW-1:0]  sram_wdata_o,
  output logic [DataW/8-1:0] sram_wmask_o,
  input  logic [DataW-1:0]  sram_rdata_i
);

  localparam int unsigned MaskW = DataW / 8;
  localparam int unsigned OutW  = $clog2(SramRdLat + 1);
  localparam logic [AddrW:0] DepthW = (AddrW + 1)'(Depth);
  localparam logic [AddrW:0] CntMax = {1'b1, {AddrW{1'b0}}};

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StProg
  } state_e;

  state_e state_q, state_d;

  logic [SramRdLat-1:0] rd_vld_q;
  logic [SramRdLat-1:0] rd_oor_q;
  logic [OutW-1:0]      out_q, out_d, out_ret;
  logic                 drained;
  logic [AddrW:0]       prog_cnt_q;
  logic                 werr_q;
  logic                 wr_locked;

  logic                 host_acc;
  logic                 host_in_range;
  logic                 prog_in_range;
  logic                 host_rd_acc;
  logic                 host_wr_err;
  logic                 host_sram;
  logic                 prog_wr;
  logic                 rd_vld_out;
  logic                 rd_oor_out;
  logic [MaskW-1:0]     host_bmask;

  // Host grant and access qualification
  assign host_gnt_o    = (state_q == StRun) & prog_rst_ni;
  assign host_acc      = host_req_i & host_gnt_o;
  assign host_in_range = {1'b0, host_addr_i} < DepthW;
  assign prog_in_range = {1'b0, prog_addr_i} < DepthW;

  assign host_rd_acc = host_acc & ~host_we_i;
  assign host_wr_err = host_acc & host_we_i & (~host_in_range | wr_locked);
  assign host_sram   = host_acc & host_in_range & (~host_we_i | ~wr_locked);
  assign prog_wr     = (state_q == StProg) & prog_we_i & prog_in_range;

`ifdef INSTR_MEM_WLOCK_EN
  logic lock_q;

  // Write lock: set when a programming session ends (PROG -> RUN); only rst_ni clears it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
    end else if ((state_q == StProg) && (state_d == StRun)) begin
      lock_q <= 1'b1;
    end
  end

  assign wr_locked = lock_q;
`else
  assign wr_locked = 1'b0;
`endif

  // Collapse the host bit mask into a byte mask: a byte is written if any of its bits is enabled
  always_comb begin
    host_bmask = '0;
    for (int unsigned i = 0; i < MaskW; i++) begin
      host_bmask[i] = |host_wmask_i[8*i +: 8];
    end
  end

  // SRAM port mux; the FSM state guarantees host and prog access never happen together
  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    if (host_sram) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = ~host_we_i;
      sram_addr_o  = host_addr_i;
      sram_wdata_o = host_wdata_i;
      sram_wmask_o = host_bmask;
    end else if (prog_wr) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = 1'b0;
      sram_addr_o  = prog_addr_i;
      sram_wdata_o = prog_wdata_i;
      sram_wmask_o = '1;
    end
  end

  // Read return pipe: one stage per cycle of SRAM latency, tagged with an out-of-range flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld_q <= '0;
      rd_oor_q <= '0;
    end else begin
      rd_vld_q[0] <= host_rd_acc;
      rd_oor_q[0] <= host_rd_acc & ~host_in_range;
      for (int unsigned i = 1; i < SramRdLat; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_oor_q[i] <= rd_oor_q[i-1];
      end
    end
  end

  assign rd_vld_out    = rd_vld_q[SramRdLat-1];
  assign rd_oor_out    = rd_oor_q[SramRdLat-1];
  assign host_rvalid_o = rd_vld_out;
  assign host_rdata_o  = (rd_vld_out & ~rd_oor_out) ? sram_rdata_i : '0;
  assign host_rerror_o = {rd_vld_out & rd_oor_out, 1'b0};

  // Outstanding read count: +1 on read accept, -1 on rvalid
  always_comb begin
    out_d = out_q;
    if (host_rd_acc && !rd_vld_out) begin
      out_d = out_q + OutW'(1);
    end else if (!host_rd_acc && rd_vld_out) begin
      out_d = out_q - OutW'(1);
    end
  end

  // Drain test uses the count after this cycle's return, so PROG is entered
  // right after the cycle carrying the last rvalid (no grant exists here, so no accepts)
  assign out_ret = out_q - OutW'(rd_vld_out);
  assign drained = (out_ret == '0);

  // Outstanding counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  // Mode FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Mode FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (!prog_rst_ni) begin
          state_d = drained ? StProg : StDrain;
        end
      end
      StDrain: begin
        if (prog_rst_ni) begin
          state_d = StRun;
        end else if (drained) begin
          state_d = StProg;
        end
      end
      StProg: begin
        if (prog_rst_ni) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign prog_ready_o = (state_q == StProg);

  // Programmed-word counter: cleared when leaving RUN, saturating count of accepted prog writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prog_cnt_q <= '0;
    end else if ((state_q == StRun) && (state_d != StRun)) begin
      prog_cnt_q <= '0;
    end else if (prog_wr && (prog_cnt_q != CntMax)) begin
      prog_cnt_q <= prog_cnt_q + 1'b1;
    end
  end

  assign prog_cnt_o = prog_cnt_q;

  // Write-refused pulse, one cycle after the refused host write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      werr_q <= 1'b0;
    end else begin
      werr_q <= host_wr_err;
    end
  end

  assign host_werr_o = werr_q;

endmodule

// File: tb/tb_instr_mem_bridge.sv
// Testbench for instr_mem_bridge (AddrW=12, DataW=32, Depth=3000, SramRdLat=2)
// with a behavioural SRAM model. Expected read and write-error responses are queued
// when stimulus is issued; a negedge monitor pops and compares them.
module tb_instr_mem_bridge;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 3000;
  localparam int unsigned LAT   = 2;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           prog_rst_ni;
  logic           host_req_i;
  logic           host_gnt_o;
  logic           host_we_i;
  logic [AW-1:0]  host_addr_i;
  logic [DW-1:0]  host_wdata_i;
  logic [DW-1:0]  host_wmask_i;
  logic [DW-1:0]  host_rdata_o;
  logic           host_rvalid_o;
  logic [1:0]     host_rerror_o;
  logic           host_werr_o;
  logic           prog_we_i;
  logic [AW-1:0]  prog_addr_i;
  logic [DW-1:0]  prog_wdata_i;
  logic           prog_ready_o;
  logic [AW:0]    prog_cnt_o;
  logic           sram_csb_o;
  logic           sram_web_o;
  logic [AW-1:0]  sram_addr_o;
  logic [DW-1:0]  sram_wdata_o;
  logic [DW/8-1:0] sram_wmask_o;
  logic [DW-1:0]  sram_rdata_i;

  instr_mem_bridge #(
    .AddrW    (AW),
    .DataW    (DW),
    .Depth    (DEPTH),
    .SramRdLat(LAT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .prog_rst_ni  (prog_rst_ni),
    .host_req_i   (host_req_i),
    .host_gnt_o   (host_gnt_o),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_wmask_i (host_wmask_i),
    .host_rdata_o (host_rdata_o),
    .host_rvalid_o(host_rvalid_o),
    .host_rerror_o(host_rerror_o),
    .host_werr_o  (host_werr_o),
    .prog_we_i    (prog_we_i),
    .prog_addr_i  (prog_addr_i),
    .prog_wdata_i (prog_wdata_i),
    .prog_ready_o (prog_ready_o),
    .prog_cnt_o   (prog_cnt_o),
    .sram_csb_o   (sram_csb_o),
    .sram_web_o   (sram_web_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_wmask_o (sram_wmask_o),
    .sram_rdata_i (sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // SRAM model: byte-masked writes, reads with a two-cycle latency
  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] rd_s1, rd_s2;
  always @(posedge clk_i) begin
    if (!sram_csb_o) begin
      if (!sram_web_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end else begin
        rd_s1 <= mem[sram_addr_o];
      end
    end
    rd_s2 <= rd_s1;
  end
  assign sram_rdata_i = rd_s2;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    err;
    int            at;
  } rd_exp_t;

  rd_exp_t rdq[$];
  int      werrq[$];
  int      tests = 0;
  int      fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every rvalid / werr pulse against the queued expectation
  rd_exp_t e;
  int      we_at;
  always @(negedge clk_i) begin
    if (host_rvalid_o) begin
      if (rdq.size() == 0) begin
        tests++; fails++;
        $display("FAIL rvalid_unexpected: got rvalid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = rdq.pop_front();
        chk("rdata", 64'(host_rdata_o), 64'(e.data));
        chk("rerror", 64'(host_rerror_o), 64'(e.err));
        chk("rvalid_cycle", 64'(cyc), 64'(e.at));
      end
    end
    if (host_werr_o) begin
      if (werrq.size() == 0) begin
        tests++; fails++;
        $display("FAIL werr_unexpected: got werr=1 expected none (cycle %0d)", cyc);
      end else begin
        we_at = werrq.pop_front();
        chk("werr_cycle", 64'(cyc), 64'(we_at));
      end
    end
  end

  task automatic cyc_start();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    cyc_start();
    host_req_i = 1'b0;
    prog_we_i  = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] err,
                    input bit push);
    rd_exp_t x;
    cyc_start();
    prog_we_i   = 1'b0;
    host_req_i  = 1'b1;
    host_we_i   = 1'b0;
    host_addr_i = a;
    if (push) begin
      x.data = d; x.err = err; x.at = cyc + LAT;
      rdq.push_back(x);
    end
    @(negedge clk_i);
    if (a < AW'(DEPTH)) begin
      chk("rd_csb", 64'(sram_csb_o), 64'(0));
      chk("rd_web", 64'(sram_web_o), 64'(1));
      chk("rd_addr", 64'(sram_addr_o), 64'(a));
    end else begin
      chk("rd_oor_csb", 64'(sram_csb_o), 64'(1));
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m,
                    input logic [3:0] exp_bm, input bit ok);
    cyc_start();
    prog_we_i    = 1'b0;
    host_req_i   = 1'b1;
    host_we_i    = 1'b1;
    host_addr_i  = a;
    host_wdata_i = d;
    host_wmask_i = m;
    if (!ok) werrq.push_back(cyc + 1);
    @(negedge clk_i);
    chk("wr_csb", 64'(sram_csb_o), 64'(!ok));
    chk("wr_web", 64'(sram_web_o), 64'(!ok));
    if (ok) begin
      chk("wr_wmask", 64'(sram_wmask_o), 64'(exp_bm));
      chk("wr_wdata", 64'(sram_wdata_o), 64'(d));
    end
  endtask

  task automatic pw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cyc_start();
    host_req_i   = 1'b0;
    prog_we_i    = 1'b1;
    prog_addr_i  = a;
    prog_wdata_i = d;
    @(negedge clk_i);
    if (a < AW'(DEPTH)) begin
      chk("pw_csb", 64'(sram_csb_o), 64'(0));
      chk("pw_web", 64'(sram_web_o), 64'(0));
      chk("pw_wmask", 64'(sram_wmask_o), 64'(4'hF));
      chk("pw_addr", 64'(sram_addr_o), 64'(a));
    end else begin
      chk("pw_oor_csb", 64'(sram_csb_o), 64'(1));
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h010] = 32'h1111_0010;
    mem[12'h011] = 32'h2222_0011;
    mem[12'h012] = 32'h3333_0012;
    rd_s1 = '0; rd_s2 = '0;

    rst_ni = 1'b0; prog_rst_ni = 1'b1;
    host_req_i = 1'b0; host_we_i = 1'b0; host_addr_i = '0;
    host_wdata_i = '0; host_wmask_i = '0;
    prog_we_i = 1'b0; prog_addr_i = '0; prog_wdata_i = '0;

    // Reset values
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_rvalid", 64'(host_rvalid_o), 64'(0));
    chk("rst_rerror", 64'(host_rerror_o), 64'(0));
    chk("rst_werr", 64'(host_werr_o), 64'(0));
    chk("rst_csb", 64'(sram_csb_o), 64'(1));
    chk("rst_web", 64'(sram_web_o), 64'(1));
    chk("rst_addr", 64'(sram_addr_o), 64'(0));
    chk("rst_wdata", 64'(sram_wdata_o), 64'(0));
    chk("rst_wmask", 64'(sram_wmask_o), 64'(0));
    chk("rst_prog_cnt", 64'(prog_cnt_o), 64'(0));
    chk("rst_prog_ready", 64'(prog_ready_o), 64'(0));
    chk("rst_gnt", 64'(host_gnt_o), 64'(1));
    cyc_start();
    rst_ni = 1'b1;

    // Byte-masked host write, then read back
    wr(12'h020, 32'hAABB_CCDD, 32'h0000_FF00, 4'b0010, 1'b1);
    rd(12'h020, 32'h0000_CC00, 2'b00, 1'b1);
    idle();

    // Back-to-back reads
    rd(12'h010, 32'h1111_0010, 2'b00, 1'b1);
    rd(12'h011, 32'h2222_0011, 2'b00, 1'b1);
    rd(12'h012, 32'h3333_0012, 2'b00, 1'b1);
    repeat (3) idle();

    // Out-of-range read and write
    rd(12'd3000, 32'h0, 2'b10, 1'b1);
    wr(12'd3001, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 4'hF, 1'b0);
    repeat (3) idle();

    // Drain: programming requested with two reads in flight
    rd(12'h010, 32'h1111_0010, 2'b00, 1'b1);
    rd(12'h011, 32'h2222_0011, 2'b00, 1'b1);
    idle();
    prog_rst_ni = 1'b0;
    @(negedge clk_i);
    chk("drain_gnt_fall", 64'(host_gnt_o), 64'(0));
    chk("drain_ready0", 64'(prog_ready_o), 64'(0));
    idle();
    @(negedge clk_i);
    chk("drain_gnt", 64'(host_gnt_o), 64'(0));
    chk("drain_ready1", 64'(prog_ready_o), 64'(0));
    idle();
    @(negedge clk_i);
    chk("prog_ready", 64'(prog_ready_o), 64'(1));
    chk("prog_cnt_entry", 64'(prog_cnt_o), 64'(0));

    // Programming session
    for (int i = 0; i < 5; i++) pw(AW'(i), 32'hA5A5_0000 + 32'(i));
    pw(AW'(DEPTH), 32'hFFFF_FFFF);
    idle();
    @(negedge clk_i);
    chk("prog_cnt", 64'(prog_cnt_o), 64'(5));
    chk("prog_gnt", 64'(host_gnt_o), 64'(0));
    idle();
    prog_rst_ni = 1'b1;
    @(negedge clk_i);
    chk("exit_gnt0", 64'(host_gnt_o), 64'(0));
    idle();
    @(negedge clk_i);
    chk("run_gnt", 64'(host_gnt_o), 64'(1));
    chk("run_ready", 64'(prog_ready_o), 64'(0));
    for (int i = 0; i < 5; i++) rd(AW'(i), 32'hA5A5_0000 + 32'(i), 2'b00, 1'b1);
    repeat (3) idle();

    // Host write after a programming session
`ifdef INSTR_MEM_WLOCK_EN
    wr(12'h030, 32'h1234_5678, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd(12'h030, 32'h0, 2'b00, 1'b1);
`else
    wr(12'h030, 32'h1234_5678, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(12'h030, 32'h1234_5678, 2'b00, 1'b1);
`endif
    repeat (3) idle();
    rst_ni = 1'b0;
    idle();
    rst_ni = 1'b1;
    wr(12'h030, 32'h8765_4321, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(12'h030, 32'h8765_4321, 2'b00, 1'b1);
    repeat (3) idle();

    // Reset in the middle of a read: its rvalid must never appear
    rd(12'h011, 32'h0, 2'b00, 1'b0);
    idle();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("midrst_rvalid0", 64'(host_rvalid_o), 64'(0));
    idle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("midrst_rvalid1", 64'(host_rvalid_o), 64'(0));
    repeat (4) idle();

    chk("rdq_empty", 64'(rdq.size()), 64'(0));
    chk("werrq_empty", 64'(werrq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
